// File: rtl/sc_reg_writeback_pkg.sv
// Shared types and constants for the register write-back block.
// FSM encoding, queue depth and strobe-counter width live here so both files agree.
package sc_reg_writeback_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STROBE = 1'b1
    } wb_state_t;

    localparam int WB_FIFO_DEPTH = 2;
    localparam int WB_FIFO_CNT_W = $clog2(WB_FIFO_DEPTH + 1);
    localparam int WB_WCNT_W     = 16;

    // A single-register file still needs a one-bit index port.
    function automatic int wb_addr_width(input int numreg);
        return (numreg > 1) ? $clog2(numreg) : 1;
    endfunction

endpackage

// File: rtl/sc_reg_writeback_fifo.sv
// Two-entry {addr,data} queue exposing head and second entry; pop of head one edge after it is read.
// Push is ignored when full and pop when empty; flush clears occupancy synchronously.
module sc_reg_writeback_fifo
    import sc_reg_writeback_pkg::*;
#(
    parameter int PAYLOAD_W = 35
) (
    input  logic                     SC_RegGENERAL_CLOCK_50,
    input  logic                     SC_RegGENERAL_RESET_InHigh,
    input  logic                     i_push,
    input  logic [PAYLOAD_W-1:0]     i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [PAYLOAD_W-1:0]     o_head_dat,
    output logic [PAYLOAD_W-1:0]     o_next_dat,
    output logic [WB_FIFO_CNT_W-1:0] o_count
);

    localparam logic [WB_FIFO_CNT_W-1:0] FULL_CNT = WB_FIFO_CNT_W'(WB_FIFO_DEPTH);
    localparam logic [WB_FIFO_CNT_W-1:0] ONE_CNT  = WB_FIFO_CNT_W'(1);

    logic [PAYLOAD_W-1:0]     r_mem [WB_FIFO_DEPTH];
    logic                     r_rd_ptr;
    logic                     r_wr_ptr;
    logic [WB_FIFO_CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign w_push_ok = i_push && (r_count != FULL_CNT) && !i_flush;
    assign w_pop_ok  = i_pop && (r_count != '0) && !i_flush;

    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_next_dat = r_mem[~r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/sc_reg_writeback.sv
// Queues register writes and drives one active-low strobe per cycle plus a shared data bus; option SC_REG_WRITEBACK_R0_ZERO_EN makes register 0 read-only zero.
// Latency: accepted at edge N, strobe low during cycle N+1; WB_Req_Ready drops when the 2-entry queue is full.
module sc_reg_writeback
    import sc_reg_writeback_pkg::*;
#(
    parameter  int DATAWIDTH_BUS = 32,
    parameter  int NUMREG        = 8,
    localparam int ADDRWIDTH     = wb_addr_width(NUMREG)
) (
    input  logic                     SC_RegGENERAL_CLOCK_50,
    input  logic                     SC_RegGENERAL_RESET_InHigh,
    input  logic                     WB_Req_Valid,
    input  logic [ADDRWIDTH-1:0]     WB_Req_Addr,
    input  logic [DATAWIDTH_BUS-1:0] WB_Req_Data,
    output logic                     WB_Req_Ready,
    input  logic                     WB_Flush,
    output logic [NUMREG-1:0]        WB_Write_OutLow,
    output logic [DATAWIDTH_BUS-1:0] WB_DataBUS_Out,
    output logic                     WB_Busy,
    output logic [WB_WCNT_W-1:0]     WB_WriteCount
);

    localparam int PAYLOAD_W = ADDRWIDTH + DATAWIDTH_BUS;
    localparam logic [WB_FIFO_CNT_W-1:0] FULL_CNT = WB_FIFO_CNT_W'(WB_FIFO_DEPTH);

    wb_state_t r_state;
    wb_state_t w_state_nxt;

    logic [WB_FIFO_CNT_W-1:0] w_fifo_count;
    logic [PAYLOAD_W-1:0]     w_head_dat;
    logic [PAYLOAD_W-1:0]     w_next_dat;
    logic [PAYLOAD_W-1:0]     w_sel_dat;
    logic [ADDRWIDTH-1:0]     w_sel_addr;
    logic [DATAWIDTH_BUS-1:0] w_sel_data;
    logic                     w_fifo_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_addr_ok;
    logic                     w_issue;
    logic [NUMREG-1:0]        w_strobe_nxt;

    logic [NUMREG-1:0]        r_strobe_n;
    logic [DATAWIDTH_BUS-1:0] r_bus;
    logic [WB_WCNT_W-1:0]     r_wcnt;

    assign w_fifo_full = (w_fifo_count == FULL_CNT);
    assign w_push      = WB_Req_Valid && !w_fifo_full && !WB_Flush;
    // The strobed entry stays at the head until the end of its strobe cycle.
    assign w_pop       = (r_state == ST_STROBE) && !WB_Flush;

    sc_reg_writeback_fifo #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_fifo (
        .SC_RegGENERAL_CLOCK_50     (SC_RegGENERAL_CLOCK_50),
        .SC_RegGENERAL_RESET_InHigh (SC_RegGENERAL_RESET_InHigh),
        .i_push                     (w_push),
        .i_push_dat                 ({WB_Req_Addr, WB_Req_Data}),
        .i_pop                      (w_pop),
        .i_flush                    (WB_Flush),
        .o_head_dat                 (w_head_dat),
        .o_next_dat                 (w_next_dat),
        .o_count                    (w_fifo_count)
    );

    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (WB_Flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_fifo_count != '0) w_state_nxt = ST_STROBE;
                ST_STROBE: w_state_nxt = (w_fifo_full || w_push) ? ST_STROBE : ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Entry that will be strobed next cycle: head when starting, otherwise whatever follows the popped head.
    always_comb begin
        w_sel_dat = w_head_dat;
        if (r_state == ST_STROBE) begin
            w_sel_dat = w_fifo_full ? w_next_dat : {WB_Req_Addr, WB_Req_Data};
        end
    end

    assign w_sel_addr = w_sel_dat[PAYLOAD_W-1 -: ADDRWIDTH];
    assign w_sel_data = w_sel_dat[DATAWIDTH_BUS-1:0];

`ifdef SC_REG_WRITEBACK_R0_ZERO_EN
    assign w_addr_ok = (32'(w_sel_addr) < NUMREG) && (w_sel_addr != '0);
`else
    assign w_addr_ok = (32'(w_sel_addr) < NUMREG);
`endif

    always_comb begin
        w_issue      = (w_state_nxt == ST_STROBE) && w_addr_ok;
        w_strobe_nxt = '1;
        for (int i = 0; i < NUMREG; i++) begin
            if (w_issue && (32'(w_sel_addr) == i)) begin
                w_strobe_nxt[i] = 1'b0;
            end
        end
    end

    // Strobes are registered so the register file sees glitch-free write-low pulses.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            r_strobe_n <= '1;
            r_bus      <= '0;
            r_wcnt     <= '0;
        end else begin
            r_strobe_n <= w_strobe_nxt;
            if (w_issue) begin
                r_bus  <= w_sel_data;
                r_wcnt <= r_wcnt + WB_WCNT_W'(1);
            end
        end
    end

    assign WB_Req_Ready    = !w_fifo_full;
    assign WB_Write_OutLow = r_strobe_n;
    assign WB_DataBUS_Out  = r_bus;
    assign WB_WriteCount   = r_wcnt;
    assign WB_Busy         = (r_state == ST_STROBE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_sc_reg_writeback.sv
// Directed bench for sc_reg_writeback: latency, back-to-back, flush, async reset, register 0 option, counter wrap.
module tb_sc_reg_writeback;

    logic        clk;
    logic        rst;
    logic        WB_Req_Valid;
    logic [2:0]  WB_Req_Addr;
    logic [31:0] WB_Req_Data;
    logic        WB_Req_Ready;
    logic        WB_Flush;
    logic [7:0]  WB_Write_OutLow;
    logic [31:0] WB_DataBUS_Out;
    logic        WB_Busy;
    logic [15:0] WB_WriteCount;

    int n_cmp  = 0;
    int n_fail = 0;

    sc_reg_writeback #(
        .DATAWIDTH_BUS (32),
        .NUMREG        (8)
    ) dut (
        .SC_RegGENERAL_CLOCK_50     (clk),
        .SC_RegGENERAL_RESET_InHigh (rst),
        .WB_Req_Valid               (WB_Req_Valid),
        .WB_Req_Addr                (WB_Req_Addr),
        .WB_Req_Data                (WB_Req_Data),
        .WB_Req_Ready               (WB_Req_Ready),
        .WB_Flush                   (WB_Flush),
        .WB_Write_OutLow            (WB_Write_OutLow),
        .WB_DataBUS_Out             (WB_DataBUS_Out),
        .WB_Busy                    (WB_Busy),
        .WB_WriteCount              (WB_WriteCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int acc;
        int cyc;
        logic rdy;

        rst          = 1'b1;
        WB_Req_Valid = 1'b0;
        WB_Req_Addr  = '0;
        WB_Req_Data  = '0;
        WB_Flush     = 1'b0;
        #1;
        chk("rst_strobe", WB_Write_OutLow, 8'hFF);
        chk("rst_bus",    WB_DataBUS_Out, 32'h0);
        chk("rst_count",  WB_WriteCount,  16'h0);
        chk("rst_ready",  WB_Req_Ready,   1'b1);
        chk("rst_busy",   WB_Busy,        1'b0);
        step();
        step();
        rst = 1'b0;

        // Single request: strobe one cycle after acceptance.
        WB_Req_Valid = 1'b1; WB_Req_Addr = 3'd3; WB_Req_Data = 32'hA5A5_0001;
        step();
        WB_Req_Valid = 1'b0;
        chk("single_wait_strobe", WB_Write_OutLow, 8'hFF);
        chk("single_wait_busy",   WB_Busy,         1'b1);
        step();
        chk("single_strobe", WB_Write_OutLow, 8'b1111_0111);
        chk("single_bus",    WB_DataBUS_Out,  32'hA5A5_0001);
        chk("single_count",  WB_WriteCount,   16'd1);
        step();
        chk("single_after_strobe", WB_Write_OutLow, 8'hFF);
        chk("single_bus_hold",     WB_DataBUS_Out,  32'hA5A5_0001);
        chk("single_after_busy",   WB_Busy,         1'b0);

        // Three consecutive requests: queue fills, third is retried.
        WB_Req_Valid = 1'b1; WB_Req_Addr = 3'd1; WB_Req_Data = 32'h0000_0011;
        step();
        chk("b2b_ready_c2", WB_Req_Ready, 1'b1);
        WB_Req_Addr = 3'd2; WB_Req_Data = 32'h0000_0022;
        step();
        chk("b2b_strobe1",  WB_Write_OutLow, 8'hFD);
        chk("b2b_bus1",     WB_DataBUS_Out,  32'h0000_0011);
        chk("b2b_ready_c3", WB_Req_Ready,    1'b0);
        WB_Req_Addr = 3'd4; WB_Req_Data = 32'h0000_0044;
        step();
        chk("b2b_strobe2",  WB_Write_OutLow, 8'hFB);
        chk("b2b_bus2",     WB_DataBUS_Out,  32'h0000_0022);
        chk("b2b_ready_c4", WB_Req_Ready,    1'b1);
        step();
        WB_Req_Valid = 1'b0;
        chk("b2b_strobe3",  WB_Write_OutLow, 8'hEF);
        chk("b2b_bus3",     WB_DataBUS_Out,  32'h0000_0044);
        step();
        chk("b2b_idle",     WB_Write_OutLow, 8'hFF);
        chk("b2b_busy",     WB_Busy,         1'b0);
        chk("b2b_count",    WB_WriteCount,   16'd4);

        // Flush with two queued entries: in-flight strobe completes, the other is dropped.
        WB_Req_Valid = 1'b1; WB_Req_Addr = 3'd6; WB_Req_Data = 32'h0000_0066;
        step();
        WB_Req_Addr = 3'd7; WB_Req_Data = 32'h0000_0077;
        step();
        WB_Req_Valid = 1'b0;
        chk("flush_inflight", WB_Write_OutLow, 8'hBF);
        chk("flush_count_a",  WB_WriteCount,   16'd5);
        WB_Flush = 1'b1;
        step();
        WB_Flush = 1'b0;
        chk("flush_strobe", WB_Write_OutLow, 8'hFF);
        chk("flush_busy",   WB_Busy,         1'b0);
        chk("flush_ready",  WB_Req_Ready,    1'b1);
        step();
        step();
        chk("flush_strobe_late", WB_Write_OutLow, 8'hFF);
        chk("flush_count_b",     WB_WriteCount,   16'd5);
        chk("flush_bus",         WB_DataBUS_Out,  32'h0000_0066);
        WB_Flush = 1'b1; WB_Req_Valid = 1'b1; WB_Req_Addr = 3'd1; WB_Req_Data = 32'hDEAD_BEEF;
        step();
        WB_Flush = 1'b0; WB_Req_Valid = 1'b0;
        step();
        step();
        chk("flush_drop_strobe", WB_Write_OutLow, 8'hFF);
        chk("flush_drop_busy",   WB_Busy,         1'b0);
        chk("flush_drop_count",  WB_WriteCount,   16'd5);

        // Reset asserted mid-strobe acts without a clock edge.
        WB_Req_Valid = 1'b1; WB_Req_Addr = 3'd2; WB_Req_Data = 32'h0000_0707;
        step();
        WB_Req_Valid = 1'b0;
        step();
        chk("rstmid_strobe_pre", WB_Write_OutLow, 8'hFB);
        rst = 1'b1;
        #1;
        chk("rstmid_strobe", WB_Write_OutLow, 8'hFF);
        chk("rstmid_bus",    WB_DataBUS_Out,  32'h0);
        chk("rstmid_count",  WB_WriteCount,   16'h0);
        chk("rstmid_busy",   WB_Busy,         1'b0);
        step();
        rst = 1'b0;
        WB_Req_Valid = 1'b1; WB_Req_Addr = 3'd5; WB_Req_Data = 32'h0000_0808;
        step();
        WB_Req_Valid = 1'b0;
        chk("rstrel_wait",   WB_Write_OutLow, 8'hFF);
        step();
        chk("rstrel_strobe", WB_Write_OutLow, 8'hDF);
        chk("rstrel_bus",    WB_DataBUS_Out,  32'h0000_0808);
        chk("rstrel_count",  WB_WriteCount,   16'd1);
        step();

        // Register 0 write.
        WB_Req_Valid = 1'b1; WB_Req_Addr = 3'd0; WB_Req_Data = 32'h0000_1234;
        step();
        WB_Req_Valid = 1'b0;
        step();
`ifdef SC_REG_WRITEBACK_R0_ZERO_EN
        chk("r0_strobe", WB_Write_OutLow, 8'hFF);
        chk("r0_count",  WB_WriteCount,   16'd1);
        chk("r0_bus",    WB_DataBUS_Out,  32'h0000_0808);
`else
        chk("r0_strobe", WB_Write_OutLow, 8'hFE);
        chk("r0_count",  WB_WriteCount,   16'd2);
        chk("r0_bus",    WB_DataBUS_Out,  32'h0000_1234);
`endif
        step();
        chk("r0_after", WB_Write_OutLow, 8'hFF);

        // Counter wrap: 65535 streamed writes, then one more.
        rst = 1'b1;
        step();
        rst = 1'b0;
        WB_Req_Valid = 1'b1; WB_Req_Addr = 3'd5;
        acc = 0;
        cyc = 0;
        while (acc < 65535 && cyc < 70000) begin
            WB_Req_Data = 32'(acc);
            rdy = WB_Req_Ready;
            step();
            cyc++;
            if (rdy) acc++;
        end
        WB_Req_Valid = 1'b0;
        chk("wrap_accepted", 64'(acc), 64'd65535);
        for (int k = 0; k < 10 && WB_Busy; k++) step();
        chk("wrap_drain_busy", WB_Busy,       1'b0);
        chk("wrap_ffff",       WB_WriteCount, 16'hFFFF);
        chk("wrap_last_bus",   WB_DataBUS_Out, 32'd65534);
        WB_Req_Valid = 1'b1; WB_Req_Addr = 3'd5; WB_Req_Data = 32'hCAFE_0000;
        step();
        WB_Req_Valid = 1'b0;
        step();
        chk("wrap_strobe", WB_Write_OutLow, 8'hDF);
        chk("wrap_zero",   WB_WriteCount,   16'h0000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
